dac_parallel_seq_interface: RTL and testbench

- Parametrised successor to the single-channel DAC712 pass-through interface. Drives NUM_CH parallel-input, double-buffered DACs (DAC712 class) that share one data bus.
- Accepts channel-tagged codes over a valid/ready handshake and generates a timed write sequence: setup, WR strobe, hold.
- Adds optional synchronous DAC-latch update (all channels at once), a timed clear sequence, per-channel shadow readback and an error pulse for bad channel indices.
- Sits between the control-law output stage and the board-level DAC pins.

---
 rtl/dac_parallel_seq_interface.sv | 194 +++++++++++++++++++
 tb/tb_dac_parallel_seq_interface.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_parallel_seq_interface.sv
// Multi-channel DAC712-class bus sequencer: setup/strobe/hold writes,
// optional DAC-latch update, timed clear and per-channel shadow readback.
module dac_parallel_seq_interface #(
  parameter int DATA_W      = 16,
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 3,
  parameter int HOLD_CYC    = 1,
  parameter bit SYNC_UPDATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CH_W-1:0]   s_ch,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_update,
  input  logic              clr_req,
  output logic              busy,
  output logic              err,
  input  logic [CH_W-1:0]   rb_ch,
  output logic [DATA_W-1:0] rb_code,
  output logic [DATA_W-1:0] dac_data,
  output logic [NUM_CH-1:0] dac_cs_n,
  output logic              dac_a1_n,
  output logic              dac_a2_n,
  output logic              dac_wr_n,
  output logic              dac_clr_n
);

  localparam int MX0   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MX    = (MX0 > HOLD_CYC) ? MX0 : HOLD_CYC;
  localparam int CNT_W = (MX < 2) ? 1 : $clog2(MX);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_UPDATE, S_CLEAR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                upd_q, upd_d;
  logic                err_q, err_d;
  logic                rdy_en_q;
  logic [DATA_W-1:0]   shadow_q [NUM_CH];
  logic [DATA_W-1:0]   shadow_d [NUM_CH];
  logic [DATA_W-1:0]   pdata_q, pdata_d;
  logic [NUM_CH-1:0]   cs_q, cs_d;
  logic                a1_q, a1_d, a2_q, a2_d;
  logic                wr_q, wr_d, clr_q, clr_d;
  logic [NUM_CH-1:0]   sel;
  logic                done;

  assign s_ready = rdy_en_q && (state_q == S_IDLE);
  assign busy    = rdy_en_q && !s_ready;
  assign done    = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    data_d   = data_q;
    upd_d    = upd_q;
    err_d    = 1'b0;
    shadow_d = shadow_q;
    if (!done) cnt_d = cnt_q - CNT_W'(1);
    unique case (state_q)
      S_IDLE: begin
        if (s_ready && clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = CNT_W'(PULSE_CYC - 1);
          for (int i = 0; i < NUM_CH; i++) shadow_d[i] = '0;
        end else if (s_ready && s_valid) begin
          if (32'(s_ch) >= NUM_CH) begin
            err_d = 1'b1;
          end else begin
            state_d = S_SETUP;
            cnt_d   = CNT_W'(SETUP_CYC - 1);
            ch_d    = s_ch;
            data_d  = s_data;
            upd_d   = s_update;
          end
        end
      end
      S_SETUP: if (done) begin
        state_d = S_STROBE;
        cnt_d   = CNT_W'(PULSE_CYC - 1);
        for (int i = 0; i < NUM_CH; i++)
          if (ch_q == CH_W'(i)) shadow_d[i] = data_q;
      end
      S_STROBE: if (done) begin
        state_d = S_HOLD;
        cnt_d   = CNT_W'(HOLD_CYC - 1);
      end
      S_HOLD: if (done) begin
        if (upd_q || !SYNC_UPDATE) begin
          state_d = S_UPDATE;
          cnt_d   = CNT_W'(PULSE_CYC - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_UPDATE, S_CLEAR: if (done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pins are decoded from the next state so they settle on the same edge.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) sel[i] = (ch_d == CH_W'(i));
    pdata_d = '0;
    cs_d    = '1;
    a1_d    = 1'b1;
    a2_d    = 1'b1;
    wr_d    = 1'b1;
    clr_d   = 1'b1;
    unique case (state_d)
      S_SETUP, S_HOLD: begin
        pdata_d = data_d;
        cs_d    = ~sel;
        a1_d    = 1'b0;
      end
      S_STROBE: begin
        pdata_d = data_d;
        cs_d    = ~sel;
        a1_d    = 1'b0;
        wr_d    = 1'b0;
      end
      S_UPDATE: begin
        pdata_d = data_d;
        cs_d    = SYNC_UPDATE ? '0 : ~sel;
        a2_d    = 1'b0;
        wr_d    = 1'b0;
      end
      S_CLEAR: begin
        cs_d  = '0;
        clr_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    rb_code = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rb_ch == CH_W'(i)) rb_code = shadow_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ch_q     <= '0;
      data_q   <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
      pdata_q  <= '0;
      cs_q     <= '1;
      a1_q     <= 1'b1;
      a2_q     <= 1'b1;
      wr_q     <= 1'b1;
      clr_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      data_q   <= data_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
      rdy_en_q <= 1'b1;
      shadow_q <= shadow_d;
      pdata_q  <= pdata_d;
      cs_q     <= cs_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      wr_q     <= wr_d;
      clr_q    <= clr_d;
    end
  end

  assign err       = err_q;
  assign dac_data  = pdata_q;
  assign dac_cs_n  = cs_q;
  assign dac_a1_n  = a1_q;
  assign dac_a2_n  = a2_q;
  assign dac_wr_n  = wr_q;
  assign dac_clr_n = clr_q;

endmodule

// File: tb/tb_dac_parallel_seq_interface.sv
// Scoreboard bench: stimulus pushes expected pin snapshots, a negedge
// monitor pops and compares them against the DUT.
module tb_dac_parallel_seq_interface;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0, s_update = 1'b0, clr_req = 1'b0;
  logic [1:0]  s_ch = '0, rb_ch = '0;
  logic [15:0] s_data = '0;
  logic        s_ready, busy, err;
  logic [15:0] rb_code, dac_data;
  logic [3:0]  dac_cs_n;
  logic        dac_a1_n, dac_a2_n, dac_wr_n, dac_clr_n;

  logic        v3 = 1'b0;
  logic [1:0]  ch3 = '0, rbc3 = 2'd3;
  logic        rdy3, busy3, err3;
  logic [15:0] rb3, data3;
  logic [2:0]  cs3;
  logic        a1_3, a2_3, wr3, clr3;

  always #5 clk = ~clk;

  dac_parallel_seq_interface u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_ch(s_ch), .s_data(s_data), .s_update(s_update),
    .clr_req(clr_req), .busy(busy), .err(err), .rb_ch(rb_ch),
    .rb_code(rb_code), .dac_data(dac_data), .dac_cs_n(dac_cs_n),
    .dac_a1_n(dac_a1_n), .dac_a2_n(dac_a2_n), .dac_wr_n(dac_wr_n),
    .dac_clr_n(dac_clr_n)
  );

  dac_parallel_seq_interface #(.NUM_CH(3)) u_dut3 (
    .clk(clk), .rst(rst), .s_valid(v3), .s_ready(rdy3),
    .s_ch(ch3), .s_data(16'h5555), .s_update(1'b0),
    .clr_req(1'b0), .busy(busy3), .err(err3), .rb_ch(rbc3),
    .rb_code(rb3), .dac_data(data3), .dac_cs_n(cs3),
    .dac_a1_n(a1_3), .dac_a2_n(a2_3), .dac_wr_n(wr3),
    .dac_clr_n(clr3)
  );

  typedef struct {
    string       nm;
    logic [41:0] v;
  } exp_t;

  typedef struct {
    string       nm;
    logic [21:0] v;
  } exp3_t;

  exp_t  q[$];
  exp3_t q3[$];
  int    checks = 0;
  int    errors = 0;

  task automatic push(input string nm, input logic [3:0] cs,
                      input logic a1, input logic a2, input logic wr,
                      input logic clr, input logic [15:0] d,
                      input logic rdy, input logic bsy,
                      input logic [15:0] rb);
    exp_t e;
    e.nm = nm;
    e.v  = {cs, a1, a2, wr, clr, d, rdy, bsy, rb};
    q.push_back(e);
  endtask

  task automatic push_reset(input string nm);
    push(nm, 4'hF, 1, 1, 1, 1, 16'h0, 0, 0, 16'h0);
  endtask

  task automatic push_idle(input string nm, input logic [15:0] rb);
    push(nm, 4'hF, 1, 1, 1, 1, 16'h0, 1, 0, rb);
  endtask

  // Expected snapshots for the first n clocks after the accepting edge.
  task automatic push_write(input string nm, input int ch,
                            input logic [15:0] d, input bit upd,
                            input logic [15:0] rb0,
                            input logic [15:0] rb1, input int n);
    logic [3:0] cs;
    int k;
    cs = 4'hF;
    cs[ch] = 1'b0;
    k = 0;
    for (int i = 0; i < 2; i++) begin
      if (k < n) push({nm, "_setup"}, cs, 0, 1, 1, 1, d, 0, 1, rb0);
      k++;
    end
    for (int i = 0; i < 3; i++) begin
      if (k < n) push({nm, "_strobe"}, cs, 0, 1, 0, 1, d, 0, 1, rb1);
      k++;
    end
    if (k < n) push({nm, "_hold"}, cs, 0, 1, 1, 1, d, 0, 1, rb1);
    k++;
    if (upd) begin
      for (int i = 0; i < 3; i++) begin
        if (k < n) push({nm, "_update"}, 4'h0, 1, 0, 0, 1, d, 0, 1, rb1);
        k++;
      end
    end
    if (k < n) push_idle({nm, "_done"}, rb1);
  endtask

  always @(negedge clk) begin
    logic [41:0] got;
    logic [21:0] got3;
    exp_t  e;
    exp3_t e3;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = {dac_cs_n, dac_a1_n, dac_a2_n, dac_wr_n, dac_clr_n,
             dac_data, s_ready, busy, rb_code};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.nm, got, e.v);
      end
    end
    if (q3.size() > 0) begin
      e3 = q3.pop_front();
      got3 = {err3, rdy3, cs3, wr3, rb3};
      checks++;
      if (got3 !== e3.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e3.nm, got3, e3.v);
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || q3.size() > 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    if (q.size() > 0 || q3.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending %0d expected 0",
               q.size() + q3.size());
      q.delete();
      q3.delete();
    end
  endtask

  task automatic send(input logic [1:0] ch, input logic [15:0] d,
                      input logic upd);
    @(posedge clk);
    #1;
    s_valid  = 1'b1;
    s_ch     = ch;
    s_data   = d;
    s_update = upd;
    @(posedge clk);
    #1;
    s_valid  = 1'b0;
    s_ch     = ~ch;
    s_data   = ~d;
    s_update = ~upd;
  endtask

  initial begin
    push_reset("reset0");
    push_reset("reset1");
    drain();
    #1;
    rst = 1'b0;
    push_reset("post_release");
    push_idle("ready_rise", 16'h0);
    drain();

    rb_ch = 2'd2;
    send(2'd2, 16'h1234, 1'b0);
    push_write("wr_ch2", 2, 16'h1234, 0, 16'h0, 16'h1234, 99);
    drain();

    rb_ch = 2'd1;
    send(2'd1, 16'hFFFF, 1'b1);
    push_write("wr_ch1_upd", 1, 16'hFFFF, 1, 16'h0, 16'hFFFF, 99);
    drain();

    rb_ch = 2'd2;
    @(posedge clk);
    #1;
    clr_req  = 1'b1;
    s_valid  = 1'b1;
    s_ch     = 2'd3;
    s_data   = 16'hA5A5;
    s_update = 1'b0;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    for (int i = 0; i < 3; i++)
      push("clear", 4'h0, 1, 1, 1, 0, 16'h0, 0, 1, 16'h0);
    push_idle("clear_done", 16'h0);
    push_write("wr_after_clr", 3, 16'hA5A5, 0, 16'h0, 16'h0, 99);
    repeat (4) @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 16'h0;
    drain();

    @(posedge clk);
    #1;
    v3  = 1'b1;
    ch3 = 2'd3;
    @(posedge clk);
    #1;
    v3  = 1'b0;
    ch3 = 2'd0;
    q3.push_back('{nm: "err_pulse", v: {1'b1, 1'b1, 3'b111, 1'b1, 16'h0}});
    q3.push_back('{nm: "err_clear", v: {1'b0, 1'b1, 3'b111, 1'b1, 16'h0}});
    drain();

    rb_ch = 2'd0;
    send(2'd0, 16'h8000, 1'b0);
    push_write("wr_abort", 0, 16'h8000, 0, 16'h0, 16'h8000, 2);
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (dac_wr_n !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_strobe: wr_n %b expected 0", dac_wr_n);
    end
    rst = 1'b1;
    push_reset("async_reset");
    drain();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
